fifo_wr_arbiter: RTL

- Shares one sync_fifo write port between NUM_REQ independent producers.
- Each producer has a valid/ready handshake. A round-robin arbiter grants the port to one producer for a bounded burst and drives the FIFO's i_wr_en and i_data_in.
- Backpressure comes from the FIFO's o_full.
- Sits directly in front of sync_fifo, in the same clock domain.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo write-side arbiter and sync_fifo benches.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_DEPTH      = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first request found after ptr_i, cyclically,
// optionally skipping one index.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PW      = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   input  logic               excl_en_i,
   input  logic [PW-1:0]      excl_idx_i,
   output logic               any_o,
   output logic [PW-1:0]      sel_o
);

   logic [NUM_REQ-1:0] req_masked;
   logic [NUM_REQ-1:0] cand;
   logic [PW-1:0]      cand_idx [NUM_REQ];

   // cand[gi] is the request sitting gi+1 positions after the pointer
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [PW:0] sum;
         assign req_masked[gi] = req_i[gi] & ~(excl_en_i && (excl_idx_i == PW'(gi)));
         assign sum            = {1'b0, ptr_i} + (PW+1)'(gi + 1);
         assign cand_idx[gi]   = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ))
                                                          : PW'(sum);
         assign cand[gi]       = req_masked[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      any_o = |cand;
      sel_o = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_o = cand_idx[i];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port between NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
   output logic [NUM_REQ-1:0]            o_ready,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic                          o_busy,
   input  logic                          i_fifo_full,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_data
);

   localparam int            PW        = clog2_min1(NUM_REQ);
   localparam int            CW        = clog2_min1(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic          pick_any;
   logic [PW-1:0] pick_sel;
   logic          in_grant;
   logic          cur_valid;
   logic          beat;
   logic          burst_done;
   logic          release_g;

   assign in_grant   = (state_q == ST_GRANT);
   assign cur_valid  = i_valid[gidx_q];
   // Reset gates the write in the very cycle it is sampled, so a burst never leaves a partial beat
   assign beat       = in_grant & cur_valid & ~i_fifo_full & i_rst;
   assign burst_done = beat && ((cnt_q + 1'b1) == BURST_MAX);
   assign release_g  = in_grant & (burst_done | ~cur_valid);

   assign o_fifo_wr_en = beat;
   assign o_ready      = (in_grant & ~i_fifo_full & i_rst) ? grant_q : '0;
   assign o_fifo_data  = (in_grant & i_rst) ? i_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign o_grant      = grant_q;
   assign o_busy       = in_grant;

   // In GRANT the pointer equals the holder, so one selector serves both the idle and release picks
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr_pick (
      .req_i      (i_valid),
      .ptr_i      (ptr_q),
      .excl_en_i  (in_grant),
      .excl_idx_i (gidx_q),
      .any_o      (pick_any),
      .sel_o      (pick_sel)
   );

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               gidx_d  = pick_sel;
               ptr_d   = pick_sel;
               grant_d = NUM_REQ'(1) << pick_sel;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (release_g) begin
               if (pick_any) begin
                  gidx_d  = pick_sel;
                  ptr_d   = pick_sel;
                  grant_d = NUM_REQ'(1) << pick_sel;
                  cnt_d   = '0;
               end else if (burst_done) begin
                  cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         gidx_q  <= '0;
         ptr_q   <= PW'(NUM_REQ - 1);
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
